// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle controller: state codes, ALU codes,
// opcode match patterns, operation classes and fixed register addresses.
// Register-address helpers take RA so that every width variant shares one package.
package ctrl_pkg;

  // Controller states
  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_HALT  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SRL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_ABS  = 4'b0110;
  localparam logic [3:0] ALU_SEQ  = 4'b0111;
  localparam logic [3:0] ALU_SET  = 4'b1000;
  localparam logic [3:0] ALU_ADDC = 4'b1001;
  localparam logic [3:0] ALU_DEF  = 4'b0001;

  // Opcode patterns, matched against the top bits of the instruction
  localparam logic [1:0] OPC_AND   = 2'b00;
  localparam logic [1:0] OPC_ADD   = 2'b01;
  localparam logic [2:0] OPC_SET   = 3'b110;
  localparam logic [4:0] OPC_SLL   = 5'b11100;
  localparam logic [4:0] OPC_SRL   = 5'b11101;
  localparam logic [4:0] OPC_BRF   = 5'b11110;
  localparam logic [4:0] OPC_SUB   = 5'b11111;
  localparam logic [4:0] OPC_SLT   = 5'b10000;
  localparam logic [4:0] OPC_HALT  = 5'b10001;
  localparam logic [4:0] OPC_LOAD  = 5'b10010;
  localparam logic [4:0] OPC_STORE = 5'b10011;
  localparam logic [4:0] OPC_ABS   = 5'b10100;
  localparam logic [4:0] OPC_SEQ   = 5'b10101;
  localparam logic [4:0] OPC_BRB   = 5'b10110;
  localparam logic [4:0] OPC_ADDC  = 5'b10111;

  // Operation class handed from the decoder to the sequencer
  typedef enum logic [3:0] {
    OP_AND, OP_ADD, OP_SET, OP_SLL, OP_SRL, OP_BRF, OP_SUB, OP_SLT,
    OP_HALT, OP_LOAD, OP_STORE, OP_ABS, OP_SEQ, OP_BRB, OP_ADDC
  } op_e;

  // Fixed operand registers of subsigned
  localparam int SUB_A = 2;
  localparam int SUB_B = 5;

  // Accumulator is the highest register; slt compares the one below it
  function automatic int acc_addr(input int ra);
    return (1 << ra) - 1;
  endfunction

  function automatic int slt_a_addr(input int ra);
    return (1 << ra) - 2;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Purpose: maps the instruction register to op class, ALU code and register/immediate fields.
// Latency: purely combinational, no state.
// Backpressure: none; outputs follow IR, unused fields are forced to 0.
module instr_decode
  import ctrl_pkg::*;
#(
  parameter int RA = 3
) (
  input  logic [2+2*RA-1:0] ir,
  output op_e               op,
  output logic [3:0]        alu,
  output logic [RA-1:0]     rs,
  output logic [RA-1:0]     rt,
  output logic [RA-1:0]     wr,
  output logic [2*RA-2:0]   imm
);

  localparam int IW   = 2 + 2*RA;
  localparam int IMMW = IW - 3;
  localparam logic [RA-1:0] ACC   = RA'(acc_addr(RA));
  localparam logic [RA-1:0] SLT_A = RA'(slt_a_addr(RA));
  localparam logic [RA-1:0] SUB_RA = RA'(SUB_A);
  localparam logic [RA-1:0] SUB_RB = RA'(SUB_B);

  logic [1:0]    top2;
  logic [2:0]    top3;
  logic [4:0]    top5;
  logic [RA-1:0] r;

  assign top2 = ir[IW-1 -: 2];
  assign top3 = ir[IW-1 -: 3];
  assign top5 = ir[IW-1 -: 5];
  assign r    = ir[RA-1:0];

  // Prefix decode: 2-bit ALU ops, 3-bit set, then the 5-bit opcode space
  always_comb begin
    op  = OP_HALT;
    alu = ALU_DEF;
    rs  = '0;
    rt  = '0;
    wr  = '0;
    imm = '0;
    if (top2 == OPC_AND || top2 == OPC_ADD) begin
      op  = (top2 == OPC_AND) ? OP_AND : OP_ADD;
      alu = (top2 == OPC_AND) ? ALU_AND : ALU_ADD;
      wr  = ir[IW-3:RA];
      rs  = r;
      rt  = ACC;
    end else if (top3 == OPC_SET) begin
      op  = OP_SET;
      alu = ALU_SET;
      imm = ir[IMMW-1:0];
      wr  = ACC;
    end else begin
      case (top5)
        OPC_SLL:   begin op = OP_SLL;   alu = ALU_SLL;  wr = r; rs = r; rt = ACC; end
        OPC_SRL:   begin op = OP_SRL;   alu = ALU_SRL;  wr = r; rs = r; end
        OPC_BRF:   begin op = OP_BRF;   rs = r; end
        OPC_SUB:   begin op = OP_SUB;   alu = ALU_SUB;  rs = SUB_RA; rt = SUB_RB; wr = r; end
        OPC_SLT:   begin op = OP_SLT;   alu = ALU_SLT;  rs = SLT_A; rt = ACC; end
        OPC_HALT:  begin op = OP_HALT; end
        OPC_LOAD:  begin op = OP_LOAD;  rt = ACC; wr = r; end
        OPC_STORE: begin op = OP_STORE; rs = r; rt = ACC; end
        OPC_ABS:   begin op = OP_ABS;   alu = ALU_ABS;  wr = r; rs = r; end
        OPC_SEQ:   begin op = OP_SEQ;   alu = ALU_SEQ;  rs = r; rt = ACC; end
        OPC_BRB:   begin op = OP_BRB;   rs = r; end
        OPC_ADDC:  begin op = OP_ADDC;  alu = ALU_ADDC; rs = r; rt = ACC; wr = ACC; end
        default:   begin op = OP_HALT; end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Purpose: fetch/execute/memory sequencer owning IR, condition bit and memory timeout.
// Latency: fetch captured in 1 cycle, EXEC 1 cycle, MEM until ack or MEM_TIMEOUT cycles.
// Backpressure: instr_req/instr_valid handshake on fetch; memread/memwrite held until mem_ack.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int RA          = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  output logic                instr_req_o,
  input  logic                instr_valid_i,
  input  logic [2+2*RA-1:0]   instr_i,
  input  logic                cond_i,
  input  logic                mem_ack_i,
  output logic [3:0]          alucontrol_o,
  output logic [RA-1:0]       rs_addr_o,
  output logic [RA-1:0]       rt_addr_o,
  output logic [RA-1:0]       write_addr_o,
  output logic [2*RA-2:0]     immediate_o,
  output logic                regwrite_o,
  output logic                write_data_control_o,
  output logic                memread_o,
  output logic                memwrite_o,
  output logic                branchf_o,
  output logic                branchb_o,
  output logic                pc_en_o,
  output logic                cb_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int IW = 2 + 2*RA;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(MEM_TIMEOUT - 1);

  logic [2:0]      state, state_nxt;
  logic [IW-1:0]   ir;
  logic            cb, cb_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;

  op_e             op;
  logic [3:0]      dec_alu;
  logic [RA-1:0]   dec_rs, dec_rt, dec_wr;
  logic [2*RA-2:0] dec_imm;
  logic            fields_on;
  logic            is_load;

  instr_decode #(.RA(RA)) u_decode (
    .ir  (ir),
    .op  (op),
    .alu (dec_alu),
    .rs  (dec_rs),
    .rt  (dec_rt),
    .wr  (dec_wr),
    .imm (dec_imm)
  );

  // Fields only mean something while an instruction is in flight; elsewhere
  // they read 0 so reset/idle/halted outputs are all quiet.
  assign fields_on    = (state == S_EXEC) || (state == S_MEM);
  assign alucontrol_o = fields_on ? dec_alu : '0;
  assign rs_addr_o    = fields_on ? dec_rs  : '0;
  assign rt_addr_o    = fields_on ? dec_rt  : '0;
  assign write_addr_o = fields_on ? dec_wr  : '0;
  assign immediate_o  = fields_on ? dec_imm : '0;
  assign is_load      = (op == OP_LOAD);
  assign cb_o         = cb;

  // Next-state, condition-bit, timeout and per-cycle strobe generation
  always_comb begin
    state_nxt            = state;
    cb_nxt               = cb;
    tcnt_nxt             = tcnt;
    instr_req_o          = 1'b0;
    regwrite_o           = 1'b0;
    write_data_control_o = 1'b0;
    memread_o            = 1'b0;
    memwrite_o           = 1'b0;
    branchf_o            = 1'b0;
    branchb_o            = 1'b0;
    pc_en_o              = 1'b0;
    done_o               = 1'b0;
    err_o                = 1'b0;
    case (state)
      S_FETCH: begin
        instr_req_o = 1'b1;
        if (instr_valid_i) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_en_o   = 1'b1;
        case (op)
          OP_AND: regwrite_o = 1'b1;
          OP_ADD, OP_SET, OP_SLL, OP_SRL, OP_SUB, OP_ABS, OP_ADDC: regwrite_o = !cb;
          OP_SLT, OP_SEQ: cb_nxt = cond_i;
          OP_BRF: branchf_o = cb;
          OP_BRB: branchb_o = cb;
          OP_LOAD, OP_STORE: begin
            // CB set predicates the access off: behave as a plain fall-through
            if (!cb) begin
              state_nxt = S_MEM;
              pc_en_o   = 1'b0;
              tcnt_nxt  = '0;
            end
          end
          OP_HALT: begin
            state_nxt = S_HALT;
            pc_en_o   = 1'b0;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        memread_o            = is_load;
        memwrite_o           = !is_load;
        write_data_control_o = is_load;
        // Ack is checked first so an ack in the final allowed cycle completes normally
        if (mem_ack_i) begin
          regwrite_o = is_load;
          pc_en_o    = 1'b1;
          state_nxt  = S_FETCH;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
          if (tcnt == TLAST) state_nxt = S_ERR;
        end
      end
      S_HALT: done_o = 1'b1;
      S_ERR: begin
        done_o = 1'b1;
        err_o  = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // State, IR (loaded only in FETCH), condition bit and timeout counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_FETCH;
      ir    <= '0;
      cb    <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      cb    <= cb_nxt;
      tcnt  <= tcnt_nxt;
      if (state == S_FETCH && instr_valid_i) ir <= instr_i;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (RA=3 main instance, RA=4 side instance).
// Expected datapath snapshots are queued when an instruction is issued and
// compared whenever the DUT advances the PC.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] wr;
    logic [4:0] imm;
    logic       rw;
    logic       wdc;
    logic       bf;
    logic       bb;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       instr_valid = 1'b0;
  logic [7:0] instr = '0;
  logic       cond = 1'b0;
  logic       mem_ack = 1'b0;

  logic       instr_req, regwrite, wdc, memread, memwrite, branchf, branchb, pc_en, cb, done, err;
  logic [3:0] alucontrol;
  logic [2:0] rs_addr, rt_addr, write_addr;
  logic [4:0] immediate;

  logic       u4_valid = 1'b0;
  logic [9:0] u4_instr = '0;
  logic       u4_req, u4_rw, u4_wdc, u4_mr, u4_mw, u4_bf, u4_bb, u4_pc, u4_cb, u4_done, u4_err;
  logic [3:0] u4_alu;
  logic [3:0] u4_rs, u4_rt, u4_wr;
  logic [6:0] u4_imm;

  multicycle_control #(.RA(3), .MEM_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .instr_req_o(instr_req), .instr_valid_i(instr_valid), .instr_i(instr),
    .cond_i(cond), .mem_ack_i(mem_ack),
    .alucontrol_o(alucontrol), .rs_addr_o(rs_addr), .rt_addr_o(rt_addr),
    .write_addr_o(write_addr), .immediate_o(immediate),
    .regwrite_o(regwrite), .write_data_control_o(wdc),
    .memread_o(memread), .memwrite_o(memwrite),
    .branchf_o(branchf), .branchb_o(branchb), .pc_en_o(pc_en),
    .cb_o(cb), .done_o(done), .err_o(err)
  );

  multicycle_control #(.RA(4), .MEM_TIMEOUT(16)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n),
    .instr_req_o(u4_req), .instr_valid_i(u4_valid), .instr_i(u4_instr),
    .cond_i(cond), .mem_ack_i(mem_ack),
    .alucontrol_o(u4_alu), .rs_addr_o(u4_rs), .rt_addr_o(u4_rt),
    .write_addr_o(u4_wr), .immediate_o(u4_imm),
    .regwrite_o(u4_rw), .write_data_control_o(u4_wdc),
    .memread_o(u4_mr), .memwrite_o(u4_mw),
    .branchf_o(u4_bf), .branchb_o(u4_bb), .pc_en_o(u4_pc),
    .cb_o(u4_cb), .done_o(u4_done), .err_o(u4_err)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rd     = 0;
  int   n_wr     = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic obs_t mk(input int alu, input int rs, input int rt, input int wr,
                              input int imm, input int rw, input int wd, input int bf, input int bb);
    obs_t o;
    o.alu = 4'(alu); o.rs = 3'(rs); o.rt = 3'(rt); o.wr = 3'(wr); o.imm = 5'(imm);
    o.rw = 1'(rw); o.wdc = 1'(wd); o.bf = 1'(bf); o.bb = 1'(bb);
    return o;
  endfunction

  // Scoreboard side: every PC advance must match the oldest queued expectation
  always @(negedge clk) begin
    obs_t  got;
    obs_t  want;
    string t;
    if (memread)  n_rd++;
    if (memwrite) n_wr++;
    if (rst_n && pc_en) begin
      got = {alucontrol, rs_addr, rt_addr, write_addr, immediate, regwrite, wdc, branchf, branchb};
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pc_en", 32'(got), 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        chk(t, 32'(got), 32'(want));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a fetch request, optionally queue the expected snapshot, hand over one instruction
  task automatic issue(input logic [7:0] ins, input obs_t e, input bit push, input string tag);
    int n;
    n = 0;
    while (!instr_req && n < 32) begin
      step();
      n++;
    end
    chk({tag, "_fetch_ready"}, 32'(instr_req), 1);
    if (push) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    instr = ins;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  // From EXEC: sit in MEM and acknowledge in MEM cycle ack_at
  task automatic mem_xact(input int ack_at, input bit rd, input string tag);
    int base;
    base = rd ? n_rd : n_wr;
    step();
    for (int k = 1; k < ack_at; k++) step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk({tag, "_req_cycles"}, 32'((rd ? n_rd : n_wr) - base), 32'(ack_at));
    chk({tag, "_back_to_fetch"}, 32'(instr_req), 1);
  endtask

  initial begin
    int base;
    obs_t none;
    none = '0;

    do_reset();
    chk("reset_instr_req", 32'(instr_req), 1);
    chk("reset_outputs_zero",
        32'({alucontrol, rs_addr, rt_addr, write_addr, immediate, regwrite, wdc, memread,
             memwrite, branchf, branchb, pc_en, cb, done, err}), 0);

    // add with CB=0
    issue(8'h4A, mk(1, 2, 7, 1, 0, 1, 0, 0, 0), 1, "add_cb0");
    chk("add_in_exec_no_req", 32'(instr_req), 0);
    step();
    chk("add_pc_en_one_cycle", 32'(pc_en), 0);
    chk("add_back_to_fetch", 32'(instr_req), 1);

    // slt sets CB from cond
    cond = 1'b1;
    issue(8'h80, mk(5, 6, 7, 0, 0, 0, 0, 0, 0), 1, "slt");
    step();
    cond = 1'b0;
    chk("slt_cb_set", 32'(cb), 1);

    // store predicated off by CB
    base = n_wr;
    issue(8'h9B, mk(1, 3, 7, 0, 0, 0, 0, 0, 0), 1, "store_pred");
    step();
    chk("store_pred_no_mem", 32'(instr_req), 1);
    chk("store_pred_no_memwrite", 32'(n_wr - base), 0);

    issue(8'h0A, mk(0, 2, 7, 1, 0, 1, 0, 0, 0), 1, "and_cb1");
    step();
    issue(8'h4A, mk(1, 2, 7, 1, 0, 0, 0, 0, 0), 1, "add_cb1_no_write");
    step();
    issue(8'hF3, mk(1, 3, 0, 0, 0, 0, 0, 1, 0), 1, "branchf_cb1");
    step();
    issue(8'hB5, mk(1, 5, 0, 0, 0, 0, 0, 0, 1), 1, "branchb_cb1");
    step();

    // seq clears CB
    issue(8'hA8, mk(7, 0, 7, 0, 0, 0, 0, 0, 0), 1, "seq");
    step();
    chk("seq_cb_clear", 32'(cb), 0);

    issue(8'hF3, mk(1, 3, 0, 0, 0, 0, 0, 0, 0), 1, "branchf_cb0");
    step();
    issue(8'hC9, mk(8, 0, 0, 7, 9, 1, 0, 0, 0), 1, "set");
    step();

    // load acknowledged in the 3rd MEM cycle
    issue(8'h92, mk(1, 0, 7, 2, 0, 1, 1, 0, 0), 1, "load_ack3");
    chk("load_exec_no_pc_en", 32'(pc_en), 0);
    mem_xact(3, 1'b1, "load_ack3");

    // store acknowledged in the last allowed cycle
    issue(8'h9B, mk(1, 3, 7, 0, 0, 0, 0, 0, 0), 1, "store_ack16");
    mem_xact(16, 1'b0, "store_ack16");
    chk("store_ack16_no_err", 32'(err), 0);

    // store never acknowledged -> timeout
    base = n_wr;
    issue(8'h9B, none, 0, "store_timeout");
    step();
    repeat (15) step();
    chk("timeout_still_mem", 32'(memwrite), 1);
    step();
    chk("timeout_err", 32'(err), 1);
    chk("timeout_done", 32'(done), 1);
    chk("timeout_memwrite_dropped", 32'(memwrite), 0);
    chk("timeout_no_fetch", 32'(instr_req), 0);
    chk("timeout_wr_cycles", 32'(n_wr - base), 16);
    repeat (3) step();
    chk("timeout_err_sticky", 32'({err, done, instr_req}), 32'b110);

    // halt
    do_reset();
    chk("reset_clears_err", 32'({err, done}), 0);
    issue(8'h88, none, 0, "halt");
    chk("halt_exec_no_pc_en", 32'(pc_en), 0);
    step();
    chk("halt_done", 32'(done), 1);
    chk("halt_no_fetch", 32'(instr_req), 0);
    instr_valid = 1'b1;
    repeat (3) step();
    instr_valid = 1'b0;
    chk("halt_sticky", 32'({done, err, instr_req}), 32'b100);

    // reset in the middle of a load
    do_reset();
    issue(8'h92, none, 0, "load_rst");
    step();
    chk("load_rst_memread_on", 32'(memread), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("load_rst_memread_drops", 32'(memread), 0);
    chk("load_rst_fetch", 32'(instr_req), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(8'h4A, mk(1, 2, 7, 1, 0, 1, 0, 0, 0), 1, "add_after_rst");
    step();

    // RA=4 instance: add 0x10A
    u4_instr = 10'h10A;
    u4_valid = 1'b1;
    step();
    u4_valid = 1'b0;
    chk("ra4_alu", 32'(u4_alu), 1);
    chk("ra4_rs", 32'(u4_rs), 10);
    chk("ra4_rt", 32'(u4_rt), 15);
    chk("ra4_wr", 32'(u4_wr), 32'(u4_instr[7:4]));
    chk("ra4_rw_pc", 32'({u4_rw, u4_pc}), 32'b11);
    step();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
